// File: rtl/apps_info_status_pkg.sv
// Address map and firmware identity words shared by the info/status bus source.
package apps_info_status_pkg;

    localparam logic [7:0] READ_FIRMWARE_TIMESTAMP_1 = 8'h00;
    localparam logic [7:0] READ_FIRMWARE_TIMESTAMP_2 = 8'h01;
    localparam logic [7:0] READ_FIRMWARE_TIMESTAMP_3 = 8'h02;
    localparam logic [7:0] READ_FIRMWARE_REVISION_1  = 8'h03;
    localparam logic [7:0] READ_FIRMWARE_REVISION_2  = 8'h04;
    localparam logic [7:0] READ_STATUS_LIVE          = 8'h05;
    localparam logic [7:0] RW_STATUS_STICKY          = 8'h06;
    localparam logic [7:0] READ_UPTIME_LO            = 8'h07;
    localparam logic [7:0] READ_UPTIME_HI            = 8'h08;

    localparam logic [15:0] FW_TIMESTAMP_VALUE_1 = 16'h2024;
    localparam logic [15:0] FW_TIMESTAMP_VALUE_2 = 16'h0315;
    localparam logic [15:0] FW_TIMESTAMP_VALUE_3 = 16'h1742;
    localparam logic [15:0] FW_REVISION_VALUE_1  = 16'h0002;
    localparam logic [15:0] FW_REVISION_VALUE_2  = 16'h0011;

    localparam logic [15:0] BUS_NO_DATA = 16'hFFFF;

endpackage

// File: rtl/status_debounce.sv
// One status pin: 2-flop synchroniser plus DEB_CYCLES-sample debounce; level
// settles 2+DEB_CYCLES cycles after a clean step and `changed` pulses on that edge.
module status_debounce #(
    parameter int   DEB_CYCLES = 3,
    parameter logic RESET_VAL  = 1'b1
) (
    input  logic xclk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic changed
);
    logic [1:0]            sync;
    logic [DEB_CYCLES-1:0] samples;
    logic [DEB_CYCLES-1:0] samples_next;
    logic                  level_next;

    // Decide on the post-shift window so the level moves on the same edge the
    // last agreeing sample arrives.
    assign samples_next = {samples[DEB_CYCLES-2:0], sync[1]};

    always_comb begin
        level_next = level;
        if (&samples_next) begin
            level_next = 1'b1;
        end else if (~|samples_next) begin
            level_next = 1'b0;
        end
    end

    assign changed = (level_next != level);

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            sync    <= {2{RESET_VAL}};
            samples <= {DEB_CYCLES{RESET_VAL}};
            level   <= RESET_VAL;
        end else begin
            sync    <= {sync[0], pin};
            samples <= samples_next;
            level   <= level_next;
        end
    end

endmodule

// File: rtl/apps_info_status.sv
// Read-only firmware identity, debounced status with W1C sticky flags and a coherent
// 32-bit uptime; registered read data one cycle after read_qualified, no backpressure.
module apps_info_status
    import apps_info_status_pkg::*;
#(
    parameter logic [7:0]          BASE_ADDR     = 8'h00,
    parameter int                  N_STATUS      = 2,
    parameter int                  DEB_CYCLES    = 3,
    parameter logic [N_STATUS-1:0] DEB_RESET_VAL = '1,
    parameter int                  UPTIME_DIV    = 1000
) (
    input  logic                xclk,
    input  logic                reset,
    input  logic                read_qualified,
    input  logic                write_qualified,
    input  logic [7:0]          ab,
    input  logic [15:0]         db_in,
    input  logic [N_STATUS-1:0] status_in,
    output logic [15:0]         db_out,
    output logic                data_avail
);
    localparam int PW = (UPTIME_DIV > 1) ? $clog2(UPTIME_DIV) : 1;

    logic [7:0]          rel;
    logic [N_STATUS-1:0] deb;
    logic [N_STATUS-1:0] chg;
    logic [N_STATUS-1:0] sticky;
    logic [N_STATUS-1:0] clr;
    logic [15:0]         shadow;
    logic [15:0]         rd_dat;
    logic                rd_vld;
    logic [PW-1:0]       presc;
    logic                tick;
    logic [31:0]         uptime;
    logic                unused_db;

    assign rel       = ab - BASE_ADDR;
    assign unused_db = ^db_in;

    for (genvar i = 0; i < N_STATUS; i++) begin : g_status
        status_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .RESET_VAL (DEB_RESET_VAL[i])
        ) u_deb (
            .xclk   (xclk),
            .reset  (reset),
            .pin    (status_in[i]),
            .level  (deb[i]),
            .changed(chg[i])
        );
    end

    assign clr  = (write_qualified && rel == RW_STATUS_STICKY) ? db_in[N_STATUS-1:0] : '0;
    assign tick = (presc == PW'(UPTIME_DIV - 1));

    always_comb begin
        rd_dat = BUS_NO_DATA;
        rd_vld = 1'b1;
        case (rel)
            READ_FIRMWARE_TIMESTAMP_1: rd_dat = FW_TIMESTAMP_VALUE_1;
            READ_FIRMWARE_TIMESTAMP_2: rd_dat = FW_TIMESTAMP_VALUE_2;
            READ_FIRMWARE_TIMESTAMP_3: rd_dat = FW_TIMESTAMP_VALUE_3;
            READ_FIRMWARE_REVISION_1:  rd_dat = FW_REVISION_VALUE_1;
            READ_FIRMWARE_REVISION_2:  rd_dat = FW_REVISION_VALUE_2;
            READ_STATUS_LIVE:          rd_dat = 16'(deb);
            RW_STATUS_STICKY:          rd_dat = 16'(sticky);
            READ_UPTIME_LO:            rd_dat = uptime[15:0];
            READ_UPTIME_HI:            rd_dat = shadow;
            default:                   rd_vld = 1'b0;
        endcase
    end

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            db_out     <= 16'h0000;
            data_avail <= 1'b0;
            shadow     <= 16'h0000;
            sticky     <= '0;
            presc      <= '0;
            uptime     <= 32'h0000_0000;
        end else begin
            if (read_qualified) begin
                db_out     <= rd_dat;
                data_avail <= rd_vld;
                // Both halves come from the pre-increment count, even on a tick edge.
                if (rel == READ_UPTIME_LO) begin
                    shadow <= uptime[31:16];
                end
            end
            sticky <= (sticky & ~clr) | chg;
            presc  <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                uptime <= uptime + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_apps_info_status.sv
// Directed bench: reads push expected words into a scoreboard, a monitor checks them.
module tb_apps_info_status;

    localparam logic [7:0] BASE = 8'h40;

    logic        xclk = 1'b0;
    logic        reset;
    logic        read_qualified;
    logic        write_qualified;
    logic [7:0]  ab;
    logic [15:0] db_in;
    logic [1:0]  status_in;
    logic [15:0] db_out;
    logic        data_avail;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_dat_q[$];
    logic        exp_vld_q[$];
    string       exp_name_q[$];

    always #5 xclk = ~xclk;

    apps_info_status #(
        .BASE_ADDR    (BASE),
        .N_STATUS     (2),
        .DEB_CYCLES   (3),
        .DEB_RESET_VAL(2'b11),
        .UPTIME_DIV   (1)
    ) dut (
        .xclk           (xclk),
        .reset          (reset),
        .read_qualified (read_qualified),
        .write_qualified(write_qualified),
        .ab             (ab),
        .db_in          (db_in),
        .status_in      (status_in),
        .db_out         (db_out),
        .data_avail     (data_avail)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic do_read(input logic [7:0] off, input logic [15:0] d, input logic v,
                           input string name);
        exp_dat_q.push_back(d);
        exp_vld_q.push_back(v);
        exp_name_q.push_back(name);
        ab             = BASE + off;
        read_qualified = 1'b1;
        @(negedge xclk);
        read_qualified = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] off, input logic [15:0] d);
        ab              = BASE + off;
        db_in           = d;
        write_qualified = 1'b1;
        @(negedge xclk);
        write_qualified = 1'b0;
    endtask

    task automatic do_read_write(input logic [7:0] off, input logic [15:0] wd,
                                 input logic [15:0] d, input string name);
        exp_dat_q.push_back(d);
        exp_vld_q.push_back(1'b1);
        exp_name_q.push_back(name);
        ab              = BASE + off;
        db_in           = wd;
        read_qualified  = 1'b1;
        write_qualified = 1'b1;
        @(negedge xclk);
        read_qualified  = 1'b0;
        write_qualified = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge xclk);
    endtask

    initial begin : monitor
        logic        pend;
        logic [15:0] ed;
        logic        ev;
        string       nm;
        forever begin
            @(posedge xclk);
            pend = read_qualified && reset;
            #1;
            if (pend) begin
                if (exp_dat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got db_out 0x%0h, expected no response", db_out);
                end else begin
                    ed = exp_dat_q.pop_front();
                    ev = exp_vld_q.pop_front();
                    nm = exp_name_q.pop_front();
                    check({nm, "_dat"}, 32'(db_out), 32'(ed));
                    check({nm, "_vld"}, 32'(data_avail), 32'(ev));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset           = 1'b1;
        read_qualified  = 1'b0;
        write_qualified = 1'b0;
        ab              = 8'h00;
        db_in           = 16'h0000;
        status_in       = 2'b11;
        #1 reset = 1'b0;
        idle(3);
        check("rst_db_out", 32'(db_out), 32'h0000);
        check("rst_avail", 32'(data_avail), 32'h0);
        check("rst_deb", 32'(dut.deb), 32'h3);
        check("rst_uptime", dut.uptime, 32'h0);
        reset = 1'b1;

        // Identity and decode; the first edge after reset sees uptime 0.
        do_read(8'h07, 16'h0000, 1'b1, "uptime_first");
        do_read(8'h08, 16'h0000, 1'b1, "shadow_first");
        do_read(8'h00, 16'h2024, 1'b1, "ts1");
        do_read(8'h01, 16'h0315, 1'b1, "ts2");
        do_read(8'h02, 16'h1742, 1'b1, "ts3");
        do_read(8'h03, 16'h0002, 1'b1, "rev1");
        do_read(8'h04, 16'h0011, 1'b1, "rev2");
        idle(3);
        check("hold_dat", 32'(db_out), 32'h0011);
        check("hold_vld", 32'(data_avail), 32'h1);
        do_read(8'h09, 16'hFFFF, 1'b0, "addr_above");
        do_read(8'hFF, 16'hFFFF, 1'b0, "addr_below");
        idle(2);
        check("hold_invalid_dat", 32'(db_out), 32'hFFFF);
        check("hold_invalid_vld", 32'(data_avail), 32'h0);
        do_read(8'h05, 16'h0003, 1'b1, "status_idle");
        do_read(8'h06, 16'h0000, 1'b1, "sticky_idle");

        // Debounce latency: 2 sync + 3 samples = 5 edges.
        status_in = 2'b10;
        idle(4);
        check("deb_lat_edge4", 32'(dut.deb), 32'h3);
        idle(1);
        check("deb_lat_edge5", 32'(dut.deb), 32'h2);
        check("sticky_same_edge", 32'(dut.sticky), 32'h1);
        do_read(8'h05, 16'h0002, 1'b1, "status_fall");
        do_read(8'h06, 16'h0001, 1'b1, "sticky_fall");
        do_write(8'h06, 16'h0001);
        do_read(8'h06, 16'h0000, 1'b1, "sticky_cleared");
        status_in = 2'b11;
        idle(6);
        do_read(8'h05, 16'h0003, 1'b1, "status_rise");
        do_read(8'h06, 16'h0001, 1'b1, "sticky_rise");
        do_write(8'h05, 16'h0001);
        do_read(8'h06, 16'h0001, 1'b1, "write_other_ignored");
        do_write(8'h06, 16'h0001);

        // Two-sample glitch is rejected.
        status_in = 2'b10;
        idle(2);
        status_in = 2'b11;
        idle(8);
        do_read(8'h05, 16'h0003, 1'b1, "glitch_status");
        do_read(8'h06, 16'h0000, 1'b1, "glitch_sticky");

        // Clear lands on the same edge the debounced bit changes: set wins.
        status_in = 2'b10;
        idle(4);
        do_write(8'h06, 16'h0001);
        do_read(8'h06, 16'h0001, 1'b1, "race_set_wins");
        do_read_write(8'h06, 16'h0001, 16'h0001, "rw_pre_clear");
        do_read(8'h06, 16'h0000, 1'b1, "race_later_clear");

        // Uptime coherence across a low-half carry.
        force dut.uptime = 32'h0000_FFFF;
        #1 release dut.uptime;
        do_read(8'h07, 16'hFFFF, 1'b1, "cohere_lo");
        do_read(8'h08, 16'h0000, 1'b1, "cohere_hi");
        do_read(8'h07, 16'h0001, 1'b1, "carry_lo");
        do_read(8'h08, 16'h0001, 1'b1, "carry_hi");

        // Full 32-bit wrap.
        force dut.uptime = 32'hFFFF_FFFF;
        #1 release dut.uptime;
        idle(1);
        do_read(8'h07, 16'h0000, 1'b1, "wrap_lo");
        do_read(8'h08, 16'h0000, 1'b1, "wrap_hi");

        // Reset asserted the cycle after a read strobe.
        status_in = 2'b00;
        idle(6);
        do_read(8'h05, 16'h0000, 1'b1, "pre_reset_status");
        reset = 1'b0;
        #1;
        check("mid_rst_db_out", 32'(db_out), 32'h0000);
        check("mid_rst_avail", 32'(data_avail), 32'h0);
        check("mid_rst_deb", 32'(dut.deb), 32'h3);
        check("mid_rst_uptime", dut.uptime, 32'h0);
        check("mid_rst_sticky", 32'(dut.sticky), 32'h0);
        status_in = 2'b11;
        @(negedge xclk);
        reset = 1'b1;
        do_read(8'h07, 16'h0000, 1'b1, "post_rst_uptime");
        do_read(8'h05, 16'h0003, 1'b1, "post_rst_status");
        do_read(8'h06, 16'h0000, 1'b1, "post_rst_sticky");

        idle(2);
        check("scoreboard_drained", exp_dat_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apps_info_status.md
# apps_info_status

Read-only information and status block on the DSP parallel bus, successor to the fixed firmware-identity reader. It returns the firmware timestamp and revision words, plus a parametrised bank of debounced status inputs with write-1-to-clear sticky change flags, and a coherent 32-bit uptime counter. It is instantiated once per FPGA as one bus-out source muxed by the top level through `data_avail`.

## Interface
- `BASE_ADDR`, default 0: offset added to every address below; constants come from the shared address defs.
- `N_STATUS`, default 2: number of status input channels, 1..16.
- `DEB_CYCLES`, default 3: consecutive equal synchronised samples needed to accept a new level, 2..15.
- `DEB_RESET_VAL`, default all ones: debounced value loaded at reset, `N_STATUS` bits.
- `UPTIME_DIV`, default 1000: xclk cycles per uptime tick, at least 1.
- `xclk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low.
- `read_qualified`, in, 1: one-cycle read strobe from the bus interface.
- `write_qualified`, in, 1: one-cycle write strobe.
- `ab`, in, 8: address bus.
- `db_in`, in, 16: write data.
- `status_in`, in, `N_STATUS`: asynchronous IO pins.
- `db_out`, out, 16: registered read data.
- `data_avail`, out, 1: registered; 1 when `db_out` holds a valid response for this block.

## Operation
- **Read map** (all addresses relative to `BASE_ADDR`):
  - +0, +1, +2: `FW_TIMESTAMP_VALUE_1..3`.
  - +3, +4: `FW_REVISION_VALUE_1..2`.
  - +5: debounced status, zero-extended.
  - +6: sticky flags, zero-extended.
  - +7: uptime[15:0]. Reading it captures uptime[31:16] into a shadow register on the same edge.
  - +8: the shadow register.
  - Any other address: `db_out` = 0xFFFF, `data_avail` = 0.
- **Write map**:
  - +6: write-1-to-clear of sticky bits `db_in[N_STATUS-1:0]`.
  - All other writes are ignored.
- **Outputs without a strobe:** when `read_qualified` = 0, `db_out` and `data_avail` hold their previous values.
- **Debounce, per channel:**
  - 2-flop synchroniser, then a `DEB_CYCLES`-deep sample shift register.
  - The debounced bit becomes 1 when all samples are 1, becomes 0 when all are 0, and otherwise holds.
- **Sticky flags:**
  - A bit sets on any change of its debounced bit, in either direction.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Uptime:**
  - A prescaler counts 0..`UPTIME_DIV`-1. On wrap it increments a 32-bit counter, which wraps 0xFFFFFFFF→0.
  - If the capture and an increment happen in the same cycle, the pre-increment value is returned and shadowed.

## Timing
- **Reset values:**
  - `db_out` = 0x0000, `data_avail` = 0.
  - Synchronisers, sample registers and debounced value = `DEB_RESET_VAL`.
  - Sticky flags, shadow, prescaler and uptime counter = 0.
- **Read latency:** data is valid on the edge after the `read_qualified` cycle, i.e. 1 cycle.
- **Debounce latency:** a clean pin step is visible in the debounced value 2 + `DEB_CYCLES` cycles after the pin changes. The sticky bit sets on that same edge.
- **Glitch rejection:** a pulse shorter than `DEB_CYCLES` synchronised samples never changes the debounced value.
- **Simultaneous strobes:** read and write strobes in the same cycle are both serviced. A read of +6 returns the flags before the clear.
- **Async reset mid-operation:** forces all reset values immediately, with no partial state retained.

## Structure
- The address constants go in the shared address defs: `READ_FIRMWARE_*`, `READ_STATUS_LIVE`, `RW_STATUS_STICKY`, `READ_UPTIME_LO`, `READ_UPTIME_HI`.
- The `FW_*_VALUE` constants go there as well.
- One sub-module, `status_debounce`: synchroniser, debounce and change pulse for one channel, parametrised by `DEB_CYCLES`. It is instantiated `N_STATUS` times with a generate loop.
- The prescaler and uptime counter stay inline.

## Test plan
1. **Identity and decode:** with reset released and `BASE_ADDR` = 0x40, read 0x40..0x44 → the `FW_*` constants with `data_avail` = 1 one cycle later. Read 0x49 → 0xFFFF with `data_avail` = 0.
2. **Debounce:**
   - `status_in[0]` driven 1→0 and held → debounced value reads 0x0002 after 5 cycles and sticky reads 0x0001.
   - A 2-cycle low glitch → debounced value stays 0x0003 and sticky stays 0.
3. **Sticky clear race:** write 0x0001 to +6 in the same cycle channel 0 toggles its debounced value → sticky bit 0 remains 1. A later write 0x0001 → it reads 0.
4. **Uptime coherence:** with `UPTIME_DIV` = 1, preload by running until uptime = 0x0000FFFF, then read +7 → 0xFFFF. The following read of +8 → 0x0000, not 0x0001.
5. **Wrap:** counter at 0xFFFFFFFF plus one tick → reads of +7 then +8 give 0x0000 and 0x0000.
6. **Reset mid-read:** assert `reset` the cycle after `read_qualified` → `db_out` = 0x0000, `data_avail` = 0, debounced value = `DEB_RESET_VAL`, uptime = 0.
